// File: rtl/tff_count_sequencer_if.sv
// tff_count_sequencer_if: control and status bundle between a controller and the T-flop count sequencer
interface tff_count_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             Start_In;
    logic             Stop_In;
    logic             Dir_In;
    logic             Reload_In;
    logic [WIDTH-1:0] Limit_In;
    logic [WIDTH-1:0] Count_Out;
    logic [WIDTH-1:0] T_Out;
    logic             Busy_Out;
    logic             Done_Out;
    logic             Wrap_Out;

    modport master (
        output Start_In, Stop_In, Dir_In, Reload_In, Limit_In,
        input  Count_Out, T_Out, Busy_Out, Done_Out, Wrap_Out
    );

    modport slave (
        input  Start_In, Stop_In, Dir_In, Reload_In, Limit_In,
        output Count_Out, T_Out, Busy_Out, Done_Out, Wrap_Out
    );
endinterface

// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer: bounded up/down counter built from a T flip-flop bank with optional auto-reload
module tff_count_sequencer #(
    parameter int WIDTH = 4
) (
    input logic Clk_In,
    input logic Reset_In,
    tff_count_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             dir_q, dir_d;
    logic             rel_q, rel_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] t_act;
    logic [WIDTH-1:0] s_val;
    logic [WIDTH-1:0] e_val;
    logic             at_end;

    assign s_val  = dir_q ? '0 : lim_q;
    assign e_val  = dir_q ? lim_q : '0;
    assign at_end = cnt_q == e_val;

    // Bit i toggles when all lower bits are 1 (up) or all 0 (down)
    assign tgl[0] = 1'b1;
    for (genvar g = 1; g < WIDTH; g++) begin : g_tgl
        assign tgl[g] = dir_q ? &cnt_q[g-1:0] : &(~cnt_q[g-1:0]);
    end

    assign t_act = (state_q == RUN && !at_end && !bus.Stop_In) ? tgl : '0;

    // Next-state, count and latch logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        dir_d   = dir_q;
        rel_d   = rel_q;
        wrap_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.Stop_In) begin
                    state_d = IDLE;
                end else if (at_end && rel_q) begin
                    cnt_d  = s_val;
                    wrap_d = 1'b1;
                end else if (at_end) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q ^ t_act;
                end
            end
            default: begin
                state_d = IDLE;
                if (!bus.Stop_In && bus.Start_In) begin
                    state_d = RUN;
                    dir_d   = bus.Dir_In;
                    lim_d   = bus.Limit_In;
                    rel_d   = bus.Reload_In;
                    cnt_d   = bus.Dir_In ? '0 : bus.Limit_In;
                end
            end
        endcase
    end

    // State and T-bank register with synchronous reset
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lim_q   <= '0;
            dir_q   <= 1'b0;
            rel_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            rel_q   <= rel_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.Count_Out = cnt_q;
    assign bus.T_Out     = t_act;
    assign bus.Busy_Out  = state_q == RUN;
    assign bus.Done_Out  = state_q == DONE;
    assign bus.Wrap_Out  = wrap_q;
endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb_tff_count_sequencer: directed scenarios for the T-flop count sequencer
module tb_tff_count_sequencer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    tff_count_sequencer_if #(.WIDTH(W)) bus ();

    tff_count_sequencer #(.WIDTH(W)) dut (
        .Clk_In  (clk),
        .Reset_In(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.Start_In  = 1'b0;
        bus.Stop_In   = 1'b0;
        bus.Dir_In    = 1'b0;
        bus.Reload_In = 1'b0;
        bus.Limit_In  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.Stop_In  = 1'($urandom_range(1));
            bus.Dir_In   = 1'($urandom_range(1));
            bus.Limit_In = W'($urandom_range(15));
        end
        checks++;
        if ({bus.Count_Out, bus.T_Out, bus.Busy_Out, bus.Done_Out, bus.Wrap_Out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got cnt=%h t=%h b=%b d=%b w=%b want all 0",
                     bus.Count_Out, bus.T_Out, bus.Busy_Out, bus.Done_Out, bus.Wrap_Out);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.Dir_In    = 1'($urandom_range(1));
            bus.Reload_In = 1'($urandom_range(1));
            bus.Limit_In  = W'($urandom_range(15));
            @(negedge clk);
            checks++;
            if (bus.Count_Out !== 4'd0 || bus.Busy_Out !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold got cnt=%h busy=%b want 0 0", bus.Count_Out, bus.Busy_Out);
            end
        end
        idle_inputs();
    endtask

    task automatic test_up();
        logic [3:0] t_exp [6] = '{4'b0001, 4'b0011, 4'b0001, 4'b0111, 4'b0001, 4'b0000};
        bus.Dir_In = 1'b1; bus.Limit_In = 4'd5; bus.Reload_In = 1'b0; bus.Start_In = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.Start_In = 1'b0;
            bus.Limit_In = 4'd1;
            checks++;
            if (bus.Busy_Out !== 1'b1 || bus.Count_Out !== 4'(i) || bus.T_Out !== t_exp[i]) begin
                failures++;
                $display("FAIL up_run[%0d] got busy=%b cnt=%h t=%b want 1 %h %b",
                         i, bus.Busy_Out, bus.Count_Out, bus.T_Out, 4'(i), t_exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.Done_Out !== 1'b1 || bus.Busy_Out !== 1'b0 || bus.Count_Out !== 4'd5) begin
            failures++;
            $display("FAIL up_done got done=%b busy=%b cnt=%h want 1 0 5", bus.Done_Out, bus.Busy_Out, bus.Count_Out);
        end
        @(negedge clk);
        checks++;
        if (bus.Done_Out !== 1'b0 || bus.Count_Out !== 4'd5) begin
            failures++;
            $display("FAIL up_after got done=%b cnt=%h want 0 5", bus.Done_Out, bus.Count_Out);
        end
        idle_inputs();
    endtask

    task automatic test_down();
        logic [3:0] c_exp [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
        logic [3:0] t_exp [4] = '{4'b0001, 4'b0011, 4'b0001, 4'b0000};
        bus.Dir_In = 1'b0; bus.Limit_In = 4'd3; bus.Start_In = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.Start_In = 1'b0;
            checks++;
            if (bus.Busy_Out !== 1'b1 || bus.Count_Out !== c_exp[i] || bus.T_Out !== t_exp[i]) begin
                failures++;
                $display("FAIL down_run[%0d] got busy=%b cnt=%h t=%b want 1 %h %b",
                         i, bus.Busy_Out, bus.Count_Out, bus.T_Out, c_exp[i], t_exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.Done_Out !== 1'b1 || bus.Count_Out !== 4'd0) begin
            failures++;
            $display("FAIL down_done got done=%b cnt=%h want 1 0", bus.Done_Out, bus.Count_Out);
        end
        idle_inputs();
    endtask

    task automatic test_reload();
        logic [3:0] c_exp [8] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
        logic       w_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.Dir_In = 1'b1; bus.Limit_In = 4'd2; bus.Reload_In = 1'b1; bus.Start_In = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.Start_In = 1'b0;
            bus.Reload_In = 1'b0;
            checks++;
            if (bus.Busy_Out !== 1'b1 || bus.Count_Out !== c_exp[i] || bus.Wrap_Out !== w_exp[i]) begin
                failures++;
                $display("FAIL reload_run[%0d] got busy=%b cnt=%h wrap=%b want 1 %h %b",
                         i, bus.Busy_Out, bus.Count_Out, bus.Wrap_Out, c_exp[i], w_exp[i]);
            end
        end
        bus.Stop_In = 1'b1;
        #1;
        checks++;
        if (bus.T_Out !== 4'b0000) begin
            failures++;
            $display("FAIL stop_t got t=%b want 0000", bus.T_Out);
        end
        @(negedge clk);
        bus.Stop_In = 1'b0;
        checks++;
        if (bus.Busy_Out !== 1'b0 || bus.Done_Out !== 1'b0 || bus.Count_Out !== 4'd1) begin
            failures++;
            $display("FAIL stop_idle got busy=%b done=%b cnt=%h want 0 0 1", bus.Busy_Out, bus.Done_Out, bus.Count_Out);
        end
        @(negedge clk);
        checks++;
        if (bus.Done_Out !== 1'b0 || bus.Count_Out !== 4'd1) begin
            failures++;
            $display("FAIL stop_nodone got done=%b cnt=%h want 0 1", bus.Done_Out, bus.Count_Out);
        end
        idle_inputs();
    endtask

    task automatic test_full();
        bus.Dir_In = 1'b1; bus.Limit_In = 4'd15; bus.Start_In = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.Start_In = 1'b0;
            checks++;
            if (bus.Count_Out !== 4'(i) || bus.Busy_Out !== 1'b1) begin
                failures++;
                $display("FAIL full_run[%0d] got cnt=%h busy=%b want %h 1", i, bus.Count_Out, bus.Busy_Out, 4'(i));
            end
            if (i == 7 || i == 15) begin
                checks++;
                if (bus.T_Out !== (i == 7 ? 4'b1111 : 4'b0000)) begin
                    failures++;
                    $display("FAIL full_t[%0d] got t=%b want %b", i, bus.T_Out, (i == 7 ? 4'b1111 : 4'b0000));
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bus.Done_Out !== 1'b1 || bus.Count_Out !== 4'd15) begin
            failures++;
            $display("FAIL full_done got done=%b cnt=%h want 1 f", bus.Done_Out, bus.Count_Out);
        end
        idle_inputs();
    endtask

    task automatic test_limit0();
        for (int d = 0; d < 2; d++) begin
            bus.Dir_In = 1'(d); bus.Limit_In = 4'd0; bus.Start_In = 1'b1;
            @(negedge clk);
            bus.Start_In = 1'b0;
            checks++;
            if (bus.Busy_Out !== 1'b1 || bus.Count_Out !== 4'd0 || bus.T_Out !== 4'd0) begin
                failures++;
                $display("FAIL lim0_run[%0d] got busy=%b cnt=%h t=%b want 1 0 0000", d, bus.Busy_Out, bus.Count_Out, bus.T_Out);
            end
            @(negedge clk);
            checks++;
            if (bus.Done_Out !== 1'b1 || bus.Count_Out !== 4'd0) begin
                failures++;
                $display("FAIL lim0_done[%0d] got done=%b cnt=%h want 1 0", d, bus.Done_Out, bus.Count_Out);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        bus.Dir_In = 1'b1; bus.Limit_In = 4'd1; bus.Start_In = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.Busy_Out !== 1'b1 || bus.Count_Out !== 4'd1) begin
            failures++;
            $display("FAIL b2b_run got busy=%b cnt=%h want 1 1", bus.Busy_Out, bus.Count_Out);
        end
        @(negedge clk);
        bus.Dir_In = 1'b0; bus.Limit_In = 4'd6;
        checks++;
        if (bus.Done_Out !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done got done=%b want 1", bus.Done_Out);
        end
        @(negedge clk);
        bus.Start_In = 1'b0;
        checks++;
        if (bus.Busy_Out !== 1'b1 || bus.Count_Out !== 4'd6 || bus.T_Out !== 4'b0011) begin
            failures++;
            $display("FAIL b2b_restart got busy=%b cnt=%h t=%b want 1 6 0011", bus.Busy_Out, bus.Count_Out, bus.T_Out);
        end
        bus.Stop_In = 1'b1;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_midreset();
        bus.Dir_In = 1'b1; bus.Limit_In = 4'd9; bus.Reload_In = 1'b1; bus.Start_In = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.Start_In = 1'b0;
        end
        checks++;
        if (bus.Count_Out !== 4'd4) begin
            failures++;
            $display("FAIL midrst_pre got cnt=%h want 4", bus.Count_Out);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.Count_Out, bus.T_Out, bus.Busy_Out, bus.Done_Out, bus.Wrap_Out} !== '0) begin
            failures++;
            $display("FAIL midrst got cnt=%h t=%h b=%b d=%b w=%b want all 0",
                     bus.Count_Out, bus.T_Out, bus.Busy_Out, bus.Done_Out, bus.Wrap_Out);
        end
        idle_inputs();
        bus.Dir_In = 1'b0; bus.Limit_In = 4'd7; bus.Start_In = 1'b1; bus.Stop_In = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.Busy_Out !== 1'b0 || bus.Count_Out !== 4'd0 || bus.T_Out !== 4'd0) begin
            failures++;
            $display("FAIL start_stop got busy=%b cnt=%h t=%b want 0 0 0000", bus.Busy_Out, bus.Count_Out, bus.T_Out);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_up();
        test_down();
        test_reload();
        test_full();
        test_limit0();
        test_back_to_back();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
